// File: rtl/oclib_uart_pkg.sv
// oclib_uart_pkg: shared UART error vector layout
package oclib_uart_pkg;
  localparam int ErrorWidth = 3;
  localparam int ErrorFraming = 0;
  localparam int ErrorBreak = 1;
  localparam int ErrorOverflow = 2;
endpackage

// File: rtl/oclib_uart_rx_filter.sv
// oclib_uart_rx_filter: synchronizes the async rx pin and deglitches it into a filtered line
module oclib_uart_rx_filter #(
  parameter int SyncCycles = 3,
  parameter int DeglitchCycles = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic rx,
  output logic line
);
  localparam int DW = $clog2(DeglitchCycles + 1);
  logic [SyncCycles-1:0] sync;
  logic [DW-1:0] run;
  logic diff, flip;
  assign diff = sync[SyncCycles-1] != line;
  assign flip = diff && run == DW'(DeglitchCycles - 1);
  always_ff @(posedge clock)
    if (reset) begin
      sync <= '1;
      run <= '0;
      line <= 1'b1;
    end else begin
      sync <= {sync[SyncCycles-2:0], rx};
      run <= diff && !flip ? run + 1'b1 : '0;
      line <= flip ? sync[SyncCycles-1] : line;
    end
endmodule

// File: rtl/oclib_uart_rx.sv
// oclib_uart_rx: 8N1 UART receiver with filtered input, byte FIFO and error pulses
module oclib_uart_rx
  import oclib_uart_pkg::*;
#(
  parameter int ClockHz = 100_000_000,
  parameter int Baud = 115200,
  parameter int SyncCycles = 3,
  parameter int DeglitchCycles = 3,
  parameter int FifoDepth = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx,
  output logic [7:0]            outData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [ErrorWidth-1:0] error,
  output logic                  active
);
  localparam int CyclesPerBit = (ClockHz + Baud / 2) / Baud;
  localparam int HalfBit = CyclesPerBit / 2;
  localparam int CW = $clog2(CyclesPerBit);
  localparam int AW = $clog2(FifoDepth);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic line, tick, push, push_ok, pop, full, frm, brk, ovf;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift;
  logic [7:0] mem [FifoDepth];
  logic [AW-1:0] wp, rp;
  logic [AW:0] fill;
  logic [ErrorWidth-1:0] err_n;
  if (CyclesPerBit < 8) begin : g_rate
    $error("oclib_uart_rx: CyclesPerBit %0d is below 8", CyclesPerBit);
  end
  oclib_uart_rx_filter #(
    .SyncCycles(SyncCycles),
    .DeglitchCycles(DeglitchCycles)
  ) u_filter (
    .clock(clock),
    .reset(reset),
    .rx(rx),
    .line(line)
  );
  assign tick = cnt == '0;
  assign outValid = fill != '0;
  assign outData = outValid ? mem[rp] : 8'h00;
  always_ff @(posedge clock) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (!line) state_n = START;
      START:     if (tick) state_n = line ? IDLE : DATA;
      DATA:      if (tick && idx == 3'd7) state_n = STOP;
      STOP:      if (tick) state_n = line ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (line) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_comb begin
    active = state == START || state == DATA || state == STOP;
    push = state == STOP && tick && line;
    brk = state == STOP && tick && !line && shift == 8'h00;
    frm = state == STOP && tick && !line && shift != 8'h00;
    pop = outValid && outReady;
    full = fill == (AW+1)'(FifoDepth);
    push_ok = push && (!full || pop);
    ovf = push && full && !pop;
    err_n = '0;
    err_n[ErrorFraming] = frm;
    err_n[ErrorBreak] = brk;
    err_n[ErrorOverflow] = ovf;
  end
  always_ff @(posedge clock)
    if (reset) begin
      cnt <= '0;
      idx <= '0;
      shift <= '0;
    end else begin
      cnt <= state == IDLE ? CW'(HalfBit - 1) :
             tick && (state == START || state == DATA) ? CW'(CyclesPerBit - 1) :
             tick ? cnt : cnt - 1'b1;
      idx <= state == DATA ? idx + {2'b00, tick} : '0;
      shift <= state == DATA && tick ? {line, shift[7:1]} : shift;
    end
  always_ff @(posedge clock)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      fill <= '0;
      error <= '0;
    end else begin
      wp <= wp + AW'(push_ok);
      rp <= rp + AW'(pop);
      fill <= fill + (AW+1)'(push_ok) - (AW+1)'(pop);
      error <= err_n;
    end
  always_ff @(posedge clock) if (push_ok) mem[wp] <= shift;
endmodule
